// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that lends one external 3-bit sequence detector to
// NUM_REQ symbol streams, a whole frame at a time, and reports one result per frame.
module seq_det_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 64,
  parameter int DET_LAT = 0,
  parameter int CNT_W   = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 det_reset_n,
  output logic [2:0]           det_data,
  input  logic                 det_found,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_hit,
  output logic [CNT_W-1:0]     res_count,
  output logic                 res_abort
);

  typedef enum logic [2:0] {IDLE, ARB, STREAM, DRAIN, REPORT} state_t;

  localparam state_t            POST_STREAM = (DET_LAT == 0) ? REPORT : DRAIN;
  localparam logic [1:0]        DRAIN_LAST  = (DET_LAT > 0) ? 2'(DET_LAT - 1) : 2'd0;
  localparam logic [LEN_W-1:0]  LEN_LAST    = LEN_W'(MAX_LEN - 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   gnt, rr_ptr, pick, srch;
  logic              pick_vld;
  logic [LEN_W-1:0]  sym_cnt;
  logic [CNT_W-1:0]  match_cnt, match_cnt_nxt;
  logic              abort, abort_nxt;
  logic [1:0]        drain_cnt;
  logic              gnt_vld, gnt_last;
  logic [2:0]        gnt_data;
  logic              accept, frame_end, win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  assign gnt_vld   = req_valid[gnt];
  assign gnt_last  = req_last[gnt];
  assign gnt_data  = req_data[3*int'(gnt) +: 3];
  assign accept    = (state == STREAM) && gnt_vld;
  // A frame leaves STREAM on a gap, on its last symbol, or when it hits MAX_LEN.
  assign frame_end = !gnt_vld || gnt_last || (sym_cnt == LEN_LAST);

  // Circular search for the first requester at or after rr_ptr.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    srch     = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_valid[srch]) begin
        pick     = srch;
        pick_vld = 1'b1;
      end
      srch = wrap_inc(srch);
    end
  end

  // Stage p0..pN: "symbol accepted" travels beside the detector latency.
  generate
    if (DET_LAT == 0) begin : g_win_comb
      assign win = accept;
    end else begin : g_win_pipe
      logic [DET_LAT-1:0] vld_p;
      always_ff @(posedge clk) begin
        if (reset) vld_p <= '0;
        else       vld_p <= (vld_p << 1) | DET_LAT'(accept);
      end
      assign win = vld_p[DET_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nxt = ARB;
      ARB:     state_nxt = STREAM;
      STREAM:  if (frame_end) state_nxt = POST_STREAM;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    det_data    = 3'd0;
    det_reset_n = 1'b1;
    unique case (state)
      IDLE, ARB: det_reset_n = 1'b0;
      STREAM: begin
        req_ready[gnt] = 1'b1;
        if (gnt_vld) det_data = gnt_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    match_cnt_nxt = match_cnt;
    abort_nxt     = abort;
    if (state == ARB) begin
      match_cnt_nxt = '0;
      abort_nxt     = 1'b0;
    end else begin
      if (win && det_found) match_cnt_nxt = sat_inc(match_cnt);
      if (state == STREAM && (!gnt_vld || (!gnt_last && sym_cnt == LEN_LAST)))
        abort_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt       <= '0;
      rr_ptr    <= '0;
      sym_cnt   <= '0;
      match_cnt <= '0;
      abort     <= 1'b0;
      drain_cnt <= 2'd0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_hit   <= 1'b0;
      res_count <= '0;
      res_abort <= 1'b0;
    end else begin
      match_cnt <= match_cnt_nxt;
      abort     <= abort_nxt;
      unique case (state)
        IDLE:   if (pick_vld) gnt <= pick;
        ARB:    sym_cnt <= '0;
        STREAM: begin
          if (accept) sym_cnt <= sym_cnt + 1'b1;
          drain_cnt <= 2'd0;
        end
        DRAIN:  drain_cnt <= drain_cnt + 2'd1;
        REPORT: rr_ptr <= wrap_inc(gnt);
        default: ;
      endcase
      // Result fields capture the final count, including a match landing this cycle.
      res_valid <= (state_nxt == REPORT);
      if (state_nxt == REPORT) begin
        res_id    <= gnt;
        res_hit   <= |match_cnt_nxt;
        res_count <= match_cnt_nxt;
        res_abort <= abort_nxt;
      end
    end
  end

endmodule
